id_stage: RTL and testbench

- Decode stage that consumes the fetch stage's pc/instruction stream; the decode end of the fetch interface.
- Holds the IF/ID pipeline register and the 8x8-bit register file.
- Decodes 16-bit instructions, resolves branches, detects hazards, and drives stall, branch_taken and branch_offset_imm back to fetch.
- Drives a registered ID/EX bundle to execute.

---
 rtl/id_stage_if.sv | 45 ++++
 rtl/id_stage.sv | 209 ++++++++++++++++++++
 tb/tb_id_stage.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// id_stage_if: bundles the fetch-side, write-back, MEM-hazard and ID/EX
// signals of the decode stage. The slave modport is the decode stage; the
// master modport is whatever surrounds it (fetch, execute, write-back).
interface id_stage_if #(
  parameter int DW = 8
);
  logic [7:0]    if_pc;
  logic [15:0]   if_instr;
  logic          wb_en;
  logic [2:0]    wb_dest;
  logic [DW-1:0] wb_data;
  logic          mem_wb_en;
  logic [2:0]    mem_dest;
  logic [DW-1:0] mem_fwd_data;
  logic          stall;
  logic          branch_taken;
  logic [5:0]    branch_offset_imm;
  logic [7:0]    ex_pc;
  logic [3:0]    ex_op;
  logic [DW-1:0] ex_val1;
  logic [DW-1:0] ex_val2;
  logic [DW-1:0] ex_st_val;
  logic [2:0]    ex_dest;
  logic [2:0]    ex_src1;
  logic [2:0]    ex_src2;
  logic          ex_wb_en;
  logic          ex_mem_read;
  logic          ex_mem_write;

  modport master (
    output if_pc, if_instr, wb_en, wb_dest, wb_data,
           mem_wb_en, mem_dest, mem_fwd_data,
    input  stall, branch_taken, branch_offset_imm,
           ex_pc, ex_op, ex_val1, ex_val2, ex_st_val,
           ex_dest, ex_src1, ex_src2, ex_wb_en, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  if_pc, if_instr, wb_en, wb_dest, wb_data,
           mem_wb_en, mem_dest, mem_fwd_data,
    output stall, branch_taken, branch_offset_imm,
           ex_pc, ex_op, ex_val1, ex_val2, ex_st_val,
           ex_dest, ex_src1, ex_src2, ex_wb_en, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: decode stage. Holds the IF/ID register and the 8x8 register file,
// decodes 16-bit instructions, resolves BR (branch when rs1 == 0), detects
// load-use and branch-operand hazards, and registers the ID/EX bundle.
// Optional macro BR_FWD_EN: the branch operand is forwarded from MEM instead
// of stalling on a MEM destination match (EX matches still stall).
module id_stage #(
  parameter int DW   = 8,
  parameter int NREG = 8
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_LD   = 4'd10;
  localparam logic [3:0] OP_ST   = 4'd11;
  localparam logic [3:0] OP_BR   = 4'd12;

  typedef struct packed {
    logic [7:0]    pc;
    logic [3:0]    op;
    logic [DW-1:0] val1;
    logic [DW-1:0] val2;
    logic [DW-1:0] st_val;
    logic [2:0]    dest;
    logic [2:0]    src1;
    logic [2:0]    src2;
    logic          wb_en;
    logic          mem_read;
    logic          mem_write;
  } ex_bundle_t;

  logic [7:0]    id_pc;
  logic [15:0]   id_instr;
  logic [DW-1:0] rf [NREG];
  ex_bundle_t    ex_q;
  ex_bundle_t    ex_d;

  logic [3:0]    op;
  logic [2:0]    rd;
  logic [2:0]    rs1;
  logic [2:0]    rs2;
  logic [2:0]    src2;
  logic [DW-1:0] imm_ext;
  logic          is_rtype;
  logic          is_addi;
  logic          is_ld;
  logic          is_st;
  logic          is_br;
  logic          use_src1;
  logic          use_src2;
  logic [DW-1:0] rs1_val;
  logic [DW-1:0] rs2_val;
  logic [DW-1:0] rd_val;
  logic [DW-1:0] br_val;
  logic          load_use;
  logic          br_stall;
  logic          stall;
  logic          taken;

  // Register read with R0 hard-wired to zero and write-through bypass.
  function automatic logic [DW-1:0] read_reg(input logic [2:0] addr,
                                             input logic [DW-1:0] stored,
                                             input logic wen,
                                             input logic [2:0] wdest,
                                             input logic [DW-1:0] wdata);
    if (addr == 3'd0)
      return '0;
    if (wen && wdest == addr)
      return wdata;
    return stored;
  endfunction

  assign op       = id_instr[15:12];
  assign rd       = id_instr[11:9];
  assign rs1      = id_instr[8:6];
  assign rs2      = id_instr[5:3];
  assign imm_ext  = {{(DW-6){id_instr[5]}}, id_instr[5:0]};
  assign is_rtype = (op >= 4'd1) && (op <= 4'd7);
  assign is_addi  = (op == OP_ADDI);
  assign is_ld    = (op == OP_LD);
  assign is_st    = (op == OP_ST);
  assign is_br    = (op == OP_BR);
  assign use_src1 = is_rtype || is_addi || is_ld || is_st || is_br;
  assign use_src2 = is_rtype || is_st;
  // ST reads its store data from the rd field, so that is its second source.
  assign src2     = is_st ? rd : rs2;

  // Read the three possible operands of the instruction sitting in ID.
  always_comb begin
    rs1_val = read_reg(rs1, rf[rs1], bus.wb_en, bus.wb_dest, bus.wb_data);
    rs2_val = read_reg(rs2, rf[rs2], bus.wb_en, bus.wb_dest, bus.wb_data);
    rd_val  = read_reg(rd,  rf[rd],  bus.wb_en, bus.wb_dest, bus.wb_data);
  end

`ifdef BR_FWD_EN
  logic mem_hit;
  assign mem_hit = bus.mem_wb_en && (bus.mem_dest == rs1) && (rs1 != 3'd0);

  // Branch operand: MEM result bypasses the register file; only EX stalls.
  always_comb begin
    br_val   = mem_hit ? bus.mem_fwd_data : rs1_val;
    br_stall = is_br && (rs1 != 3'd0) && ex_q.wb_en && (ex_q.dest == rs1);
  end
`else
  logic unused_fwd_data;
  assign unused_fwd_data = ^bus.mem_fwd_data;

  // Branch operand from the register file; pending EX or MEM writes stall.
  always_comb begin
    br_val   = rs1_val;
    br_stall = is_br && (rs1 != 3'd0) &&
               ((ex_q.wb_en && (ex_q.dest == rs1)) ||
                (bus.mem_wb_en && (bus.mem_dest == rs1)));
  end
`endif

  // Hazard detection and branch resolution; a stall always beats a branch.
  always_comb begin
    load_use = ex_q.mem_read && (ex_q.dest != 3'd0) &&
               ((use_src1 && (ex_q.dest == rs1)) ||
                (use_src2 && (ex_q.dest == src2)));
    stall    = load_use || br_stall;
    taken    = is_br && !stall && (br_val == '0);
  end

  assign bus.stall             = stall;
  assign bus.branch_taken      = taken;
  assign bus.branch_offset_imm = id_instr[5:0];

  // Build the next ID/EX bundle; stalls and branches become bubbles.
  always_comb begin
    ex_d = '0;
    if (!stall && !is_br) begin
      ex_d.pc = id_pc;
      ex_d.op = op;
      if (is_rtype) begin
        ex_d.val1  = rs1_val;
        ex_d.val2  = rs2_val;
        ex_d.dest  = rd;
        ex_d.src1  = rs1;
        ex_d.src2  = rs2;
        ex_d.wb_en = (rd != 3'd0);
      end else if (is_addi || is_ld) begin
        ex_d.val1     = rs1_val;
        ex_d.val2     = imm_ext;
        ex_d.dest     = rd;
        ex_d.src1     = rs1;
        ex_d.wb_en    = (rd != 3'd0);
        ex_d.mem_read = is_ld;
      end else if (is_st) begin
        ex_d.val1      = rs1_val;
        ex_d.val2      = imm_ext;
        ex_d.st_val    = rd_val;
        ex_d.src1      = rs1;
        ex_d.src2      = rd;
        ex_d.mem_write = 1'b1;
      end
    end
  end

  // IF/ID register: hold on stall, flush to NOP on a taken branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc    <= '0;
      id_instr <= '0;
    end else if (!stall) begin
      if (taken) begin
        id_pc    <= '0;
        id_instr <= '0;
      end else begin
        id_pc    <= bus.if_pc;
        id_instr <= bus.if_instr;
      end
    end
  end

  // Register file write port; R0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (bus.wb_en && (bus.wb_dest != 3'd0)) begin
      rf[bus.wb_dest] <= bus.wb_data;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_op        = ex_q.op;
  assign bus.ex_val1      = ex_q.val1;
  assign bus.ex_val2      = ex_q.val2;
  assign bus.ex_st_val    = ex_q.st_val;
  assign bus.ex_dest      = ex_q.dest;
  assign bus.ex_src1      = ex_q.src1;
  assign bus.ex_src2      = ex_q.src2;
  assign bus.ex_wb_en     = ex_q.wb_en;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_mem_write = ex_q.mem_write;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for id_stage. A reference model of the decode
// stage predicts stall/branch outputs each cycle and the ID/EX bundle after
// each clock; two monitors pop those predictions and compare against the DUT.
module tb_id_stage;

  typedef struct {
    logic [7:0] pc;
    logic [3:0] op;
    logic [7:0] val1;
    logic [7:0] val2;
    logic [7:0] st_val;
    logic [2:0] dest;
    logic [2:0] src1;
    logic [2:0] src2;
    logic       wb_en;
    logic       mem_read;
    logic       mem_write;
  } ex_t;

  typedef struct {
    logic       stall;
    logic       taken;
    logic [5:0] offset;
  } comb_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_stage_if bus();

  id_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int fails  = 0;

  ex_t   q_ex[$];
  comb_t q_comb[$];

  logic [7:0]  m_regs [8];
  logic [7:0]  m_pc;
  logic [15:0] m_instr;
  ex_t         m_ex;
  ex_t         m_next;
  comb_t       m_comb;

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ex_t bubble();
    ex_t b;
    b = '{default: '0};
    return b;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_pc    = 8'h00;
    m_instr = 16'h0000;
    m_ex    = bubble();
  endtask

  // Architectural register value seen by ID this cycle (writes land early).
  function automatic logic [7:0] regValue(input logic [2:0] r);
    if (r == 3'd0) return 8'h00;
    if (bus.wb_en && bus.wb_dest == r) return bus.wb_data;
    return m_regs[r];
  endfunction

  function automatic logic [7:0] signExtend6(input logic [5:0] imm);
    int v;
    v = int'(imm);
    if (v >= 32) v = v - 64;
    return 8'(v);
  endfunction

  // Predict this cycle's combinational outputs and the next EX contents.
  task automatic evaluateModel();
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [2:0] srcs[$];
    bit         load_use, br_stall, is_br;
    logic [7:0] operand;
    op  = m_instr[15:12];
    rd  = m_instr[11:9];
    rs1 = m_instr[8:6];
    rs2 = m_instr[5:3];
    is_br = (op == 4'd12);
    srcs = {};
    case (op)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin srcs.push_back(rs1); srcs.push_back(rs2); end
      4'd9, 4'd10, 4'd12: srcs.push_back(rs1);
      4'd11: begin srcs.push_back(rs1); srcs.push_back(rd); end
      default: ;
    endcase
    load_use = 0;
    if (m_ex.mem_read && m_ex.dest != 3'd0)
      foreach (srcs[k]) if (srcs[k] == m_ex.dest) load_use = 1;
    br_stall = 0;
    operand  = regValue(rs1);
    if (is_br && rs1 != 3'd0) begin
      if (m_ex.wb_en && m_ex.dest == rs1) br_stall = 1;
      if (bus.mem_wb_en && bus.mem_dest == rs1) begin
`ifdef BR_FWD_EN
        operand = bus.mem_fwd_data;
`else
        br_stall = 1;
`endif
      end
    end
    m_comb.stall  = load_use || br_stall;
    m_comb.taken  = is_br && !m_comb.stall && (operand == 8'h00);
    m_comb.offset = m_instr[5:0];

    m_next = bubble();
    if (!m_comb.stall && !is_br) begin
      m_next.pc = m_pc;
      m_next.op = op;
      if (op >= 4'd1 && op <= 4'd7) begin
        m_next.val1 = regValue(rs1); m_next.val2 = regValue(rs2);
        m_next.dest = rd; m_next.src1 = rs1; m_next.src2 = rs2;
        m_next.wb_en = (rd != 3'd0);
      end else if (op == 4'd9 || op == 4'd10) begin
        m_next.val1 = regValue(rs1); m_next.val2 = signExtend6(m_instr[5:0]);
        m_next.dest = rd; m_next.src1 = rs1;
        m_next.wb_en = (rd != 3'd0); m_next.mem_read = (op == 4'd10);
      end else if (op == 4'd11) begin
        m_next.val1 = regValue(rs1); m_next.val2 = signExtend6(m_instr[5:0]);
        m_next.st_val = regValue(rd); m_next.src1 = rs1; m_next.src2 = rd;
        m_next.mem_write = 1'b1;
      end
    end
  endtask

  // One clock of stimulus: drive at negedge, predict, then advance the model.
  task automatic applyStimulus(input logic r, input logic [7:0] pc,
                               input logic [15:0] ins, input logic we,
                               input logic [2:0] wd, input logic [7:0] wdat,
                               input logic mwe, input logic [2:0] md,
                               input logic [7:0] mfd);
    @(negedge clk);
    rst               = r;
    bus.if_pc         = pc;
    bus.if_instr      = ins;
    bus.wb_en         = we;
    bus.wb_dest       = wd;
    bus.wb_data       = wdat;
    bus.mem_wb_en     = mwe;
    bus.mem_dest      = md;
    bus.mem_fwd_data  = mfd;
    if (r) modelReset();
    evaluateModel();
    q_comb.push_back(m_comb);
    @(posedge clk);
    if (r) begin
      m_ex = bubble();
    end else begin
      m_ex = m_next;
      if (we && wd != 3'd0) m_regs[wd] = wdat;
      if (!m_comb.stall) begin
        if (m_comb.taken) begin
          m_pc = 8'h00; m_instr = 16'h0000;
        end else begin
          m_pc = pc; m_instr = ins;
        end
      end
    end
    q_ex.push_back(m_ex);
  endtask

  // Monitor for the combinational feedback to fetch.
  initial begin
    comb_t c;
    forever begin
      @(negedge clk);
      #2;
      if (q_comb.size() > 0) begin
        c = q_comb.pop_front();
        checkOutput("stall", 16'(bus.stall), 16'(c.stall));
        checkOutput("branch_taken", 16'(bus.branch_taken), 16'(c.taken));
        checkOutput("branch_offset_imm", 16'(bus.branch_offset_imm), 16'(c.offset));
      end
    end
  end

  // Monitor for the registered ID/EX bundle.
  initial begin
    ex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_ex.size() > 0) begin
        e = q_ex.pop_front();
        checkOutput("ex_pc", 16'(bus.ex_pc), 16'(e.pc));
        checkOutput("ex_op", 16'(bus.ex_op), 16'(e.op));
        checkOutput("ex_val1", 16'(bus.ex_val1), 16'(e.val1));
        checkOutput("ex_val2", 16'(bus.ex_val2), 16'(e.val2));
        checkOutput("ex_st_val", 16'(bus.ex_st_val), 16'(e.st_val));
        checkOutput("ex_dest", 16'(bus.ex_dest), 16'(e.dest));
        checkOutput("ex_src1", 16'(bus.ex_src1), 16'(e.src1));
        checkOutput("ex_src2", 16'(bus.ex_src2), 16'(e.src2));
        checkOutput("ex_wb_en", 16'(bus.ex_wb_en), 16'(e.wb_en));
        checkOutput("ex_mem_read", 16'(bus.ex_mem_read), 16'(e.mem_read));
        checkOutput("ex_mem_write", 16'(bus.ex_mem_write), 16'(e.mem_write));
      end
    end
  end

  initial begin
    logic [7:0] pc;
    rst              = 1'b1;
    bus.if_pc        = 8'h00;
    bus.if_instr     = 16'h0000;
    bus.wb_en        = 1'b0;
    bus.wb_dest      = 3'd0;
    bus.wb_data      = 8'h00;
    bus.mem_wb_en    = 1'b0;
    bus.mem_dest     = 3'd0;
    bus.mem_fwd_data = 8'h00;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] checking reset state");
    checkOutput("rst_stall", 16'(bus.stall), 16'h0);
    checkOutput("rst_branch_taken", 16'(bus.branch_taken), 16'h0);
    checkOutput("rst_ex_pc", 16'(bus.ex_pc), 16'h0);
    checkOutput("rst_ex_op", 16'(bus.ex_op), 16'h0);
    checkOutput("rst_ex_val1", 16'(bus.ex_val1), 16'h0);
    checkOutput("rst_ex_val2", 16'(bus.ex_val2), 16'h0);
    checkOutput("rst_ex_dest", 16'(bus.ex_dest), 16'h0);
    checkOutput("rst_ex_wb_en", 16'(bus.ex_wb_en), 16'h0);
    checkOutput("rst_ex_mem_read", 16'(bus.ex_mem_read), 16'h0);
    checkOutput("rst_ex_mem_write", 16'(bus.ex_mem_write), 16'h0);

    $display("[TB] directed sequences");
    // ADDI r1 = 5 at pc 0
    applyStimulus(0, 8'd0,  16'h9205, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd1,  16'h0000, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    // LD r7 then ADD using r7: one load-use stall
    applyStimulus(0, 8'd2,  16'hAECE, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd3,  16'h11C0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd4,  16'h0000, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd5,  16'h0000, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd6,  16'h0000, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    // r1 = 0, BR taken at pc 32, wrongly fetched ADDI flushed
    applyStimulus(0, 8'd32, 16'hC041, 1, 3'd1, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd33, 16'h9205, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd34, 16'h0000, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    // r1 = 1, BR not taken
    applyStimulus(0, 8'd40, 16'h0000, 1, 3'd1, 8'h01, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd41, 16'hC07B, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd42, 16'h9400, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd43, 16'h0000, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    // r2 = 7, BR on r2 while MEM writes r2 with 0
    applyStimulus(0, 8'd50, 16'h0000, 1, 3'd2, 8'h07, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd51, 16'hC080, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd52, 16'h0000, 0, 3'd0, 8'h00, 1, 3'd2, 8'h00);
    applyStimulus(0, 8'd53, 16'h0000, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd54, 16'h0000, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    // write to r0 ignored; write-through bypass on r3
    applyStimulus(0, 8'd60, 16'h1200, 1, 3'd0, 8'hFF, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd61, 16'h12C0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd62, 16'h0000, 1, 3'd3, 8'hA5, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd63, 16'h0000, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    // reset in the middle of a load-use stall
    applyStimulus(0, 8'd70, 16'hA4C1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd71, 16'h1480, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd72, 16'h0000, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(1, 8'd73, 16'h0000, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 8'd74, 16'h0000, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);

    $display("[TB] randomized stream");
    pc = 8'd80;
    for (int i = 0; i < 600; i++) begin
      logic        r, we, mwe;
      logic [15:0] ins;
      logic [7:0]  wdat, mfd;
      r   = ($urandom_range(0, 99) == 0);
      ins = {4'($urandom_range(0, 15)), 3'($urandom_range(0, 3)),
             3'($urandom_range(0, 3)), 6'($urandom)};
      we   = 1'($urandom_range(0, 1));
      wdat = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      mwe  = ($urandom_range(0, 9) < 3);
      mfd  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      applyStimulus(r, pc, ins, we, 3'($urandom_range(0, 3)), wdat,
                    mwe, 3'($urandom_range(0, 3)), mfd);
      pc = pc + 8'd1;
    end

    #6;
    checkOutput("ex_queue_drained", 16'(q_ex.size()), 16'h0);
    checkOutput("comb_queue_drained", 16'(q_comb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
